// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// PC register, branch resolution and instruction register for the multicycle
// RISC-V core. Sits upstream of the control unit: takes its PC / IR strobes and
// fetches from instruction memory over a request/valid handshake whose latency
// is not fixed.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   When defined, a watchdog bounds the WAIT state to TIMEOUT_CYC cycles. On
//   expiry a NOP (32'h00000013) is loaded, ir_valid pulses and the sticky
//   fetch_err flag sets. Without it, WAIT holds until imem_valid arrives and
//   fetch_err is tied low.
//
// Parameters
//   PC_W         width of the PC and address buses
//   RESET_PC     PC value after reset
//   TIMEOUT_CYC  fetch watchdog limit (FETCH_TIMEOUT_EN builds only)
//
// Ports
//   clock, reset_n        core clock (rising edge), async active-low reset
//   pc_write              unconditional PC load
//   pc_write_cond         PC load when the branch is taken
//   branch_op             0 = beq (take on zero), 1 = bne (take on !zero)
//   pc_src                0 = alu_result, 1 = alu_out
//   alu_result, alu_out   PC+4 (combinational) / branch target (registered)
//   alu_zero              ALU zero flag
//   load_ir               start a fetch from the current PC
//   imem_rd, imem_addr    memory read request pulse and latched address
//   imem_rdata, imem_valid memory response
//   pc                    current PC
//   instruction, ir_valid instruction register and its one-cycle update pulse
//   fetch_busy            fetch outstanding; control unit stalls
//   misaligned            sticky: fetch requested from a misaligned PC
//   fetch_err             sticky: fetch watchdog expired
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | no fetch outstanding; accepts load_ir
// REQ   | imem_rd asserted for this single cycle
// WAIT  | request issued; waiting for imem_valid (or watchdog expiry)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int              PC_W        = 64,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 16
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            pc_write,
  input  logic            pc_write_cond,
  input  logic            branch_op,
  input  logic            pc_src,
  input  logic [PC_W-1:0] alu_result,
  input  logic [PC_W-1:0] alu_out,
  input  logic            alu_zero,
  input  logic            load_ir,
  output logic            imem_rd,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instruction,
  output logic            ir_valid,
  output logic            fetch_busy,
  output logic            misaligned,
  output logic            fetch_err
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            taken;
  logic            pc_load;
  logic [PC_W-1:0] pc_next;
  logic            start_fetch;
  logic            misalign_hit;
  logic            capture;
  logic [31:0]     ir_d;
  logic            wd_expired;

  // Branch resolution: bne simply inverts the sense of the zero flag.
  assign taken   = alu_zero ^ branch_op;
  assign pc_next = pc_src ? alu_out : alu_result;
  assign pc_load = pc_write | (pc_write_cond & taken);

  assign imem_rd    = (state_q == REQ);
  assign fetch_busy = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    start_fetch  = 1'b0;
    misalign_hit = 1'b0;
    capture      = 1'b0;
    ir_d         = imem_rdata;
    unique case (state_q)
      IDLE: begin
        if (load_ir) begin
          if (pc[1:0] == 2'b00) begin
            start_fetch = 1'b1;
            state_d     = REQ;
          end else begin
            misalign_hit = 1'b1;
          end
        end
      end
      REQ: begin
        // A response this early cannot belong to our request; drop it.
        state_d = WAIT;
      end
      WAIT: begin
        if (imem_valid) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (wd_expired) begin
          capture = 1'b1;
          ir_d    = NOP;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // imem_addr samples pc before any same-edge PC update, so the fetch always
  // targets the PC the control unit saw when it raised load_ir.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc          <= RESET_PC;
      imem_addr   <= '0;
      instruction <= '0;
      ir_valid    <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_valid <= capture;
      if (pc_load) begin
        pc <= pc_next;
      end
      if (start_fetch) begin
        imem_addr <= pc;
      end
      if (capture) begin
        instruction <= ir_d;
      end
      if (misalign_hit) begin
        misaligned <= 1'b1;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  // wd_cnt counts completed WAIT cycles; expiry fires on the edge that ends
  // the TIMEOUT_CYC-th WAIT cycle.
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_hit;

  assign wd_expired  = (wd_cnt == WD_LAST);
  assign timeout_hit = (state_q == WAIT) & ~imem_valid & wd_expired;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt    <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state_q == REQ) begin
        wd_cnt <= '0;
      end else if ((state_q == WAIT) && !imem_valid && !wd_expired) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (timeout_hit) begin
        fetch_err <= 1'b1;
      end
    end
  end
`else
  assign wd_expired = 1'b0;
  assign fetch_err  = 1'b0;
`endif

endmodule
